// File: rtl/struct_pckg.sv
// Shared pipeline types for the memory stage: the EX->WB instruction record,
// LSU state encoding, access-size codes and the lane/alignment helpers.
package struct_pckg;

    localparam int unsigned DATA_W = 64;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_D  = 3'b011;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;
    localparam logic [2:0] MEM_WU = 3'b110;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic              is_valid;
        logic              mem_rd;
        logic              mem_wr;
        logic [2:0]        mem_size;
        logic [DATA_W-1:0] mem_addr;
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] rf_wr_data;
        logic              exc_misaligned;
        logic              exc_bus;
    } interconnection_struct;

    // Only the low two size bits set the access width; bit 2 selects zero-extension.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [2:0] off);
        logic mis;
        case (size[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            2'b10:   mis = |off[1:0];
            2'b11:   mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size[1:0])
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            2'b11:   base = 8'hFF;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data extraction: selects the addressed bytes of a doubleword response
// and sign- or zero-extends them according to the access size.
module lsu_load_align
    import struct_pckg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  logic [2:0]      size,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted_s;

    // Shift the addressed byte to lane 0, then extend per size.
    always_comb begin
        shifted_s = rdata >> {offset, 3'b000};
        case (size)
            MEM_B:   data = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
            MEM_H:   data = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
            MEM_W:   data = {{(XLEN-32){shifted_s[31]}}, shifted_s[31:0]};
            MEM_D:   data = shifted_s;
            MEM_BU:  data = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
            MEM_HU:  data = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
            MEM_WU:  data = {{(XLEN-32){1'b0}}, shifted_s[31:0]};
            default: data = shifted_s;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage between EX and WB: one instruction in flight, loads/stores over a
// req/gnt/rvalid data port, everything else passed through one register stage.
module mem_lsu
    import struct_pckg::*;
#(
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  interconnection_struct i_struct,
    output logic                  o_valid,
    input  logic                  i_ready,
    output interconnection_struct o_struct,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [7:0]            dmem_be,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [XLEN-1:0]       dmem_rdata
);

    localparam logic [1:0] S_IDLE = 2'(LSU_IDLE);
    localparam logic [1:0] S_REQ  = 2'(LSU_REQ);
    localparam logic [1:0] S_WAIT = 2'(LSU_WAIT);
    localparam logic [1:0] S_DONE = 2'(LSU_DONE);
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic [1:0]            state_r;
    interconnection_struct hold_r;
    logic                  req_r;
    logic                  we_r;
    logic [XLEN-1:0]       addr_r;
    logic [7:0]            be_r;
    logic [XLEN-1:0]       wdata_r;
    logic [CNT_W-1:0]      wait_cnt_r;

    logic                  accept_s;
    logic                  timeout_s;
    logic [2:0]            in_off_s;
    logic                  in_mem_s;
    logic                  misalign_s;
    logic                  issue_s;
    interconnection_struct acc_hold_s;
    logic [XLEN-1:0]       load_data_s;

    assign o_ready   = (state_r == S_IDLE) | ((state_r == S_DONE) & i_ready);
    assign accept_s  = i_valid & o_ready;
    assign timeout_s = (wait_cnt_r == CNT_W'(MAX_WAIT - 1));

    // Classify the incoming instruction and build its holding-register image.
    always_comb begin
        in_off_s   = i_struct.mem_addr[2:0];
        in_mem_s   = i_struct.is_valid & (i_struct.mem_rd | i_struct.mem_wr);
        misalign_s = in_mem_s & is_misaligned(i_struct.mem_size, in_off_s);
        issue_s    = in_mem_s & ~misalign_s;
        acc_hold_s = i_struct;
        acc_hold_s.exc_misaligned = misalign_s;
        acc_hold_s.exc_bus        = 1'b0;
    end

    lsu_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata  (dmem_rdata),
        .offset (hold_r.mem_addr[2:0]),
        .size   (hold_r.mem_size),
        .data   (load_data_s)
    );

    // FSM, holding register and registered memory-port drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            hold_r     <= '0;
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= {XLEN{1'b0}};
            be_r       <= 8'h00;
            wdata_r    <= {XLEN{1'b0}};
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            hold_r  <= acc_hold_s;
            state_r <= issue_s ? S_REQ : S_DONE;
            req_r   <= issue_s;
            we_r    <= issue_s & i_struct.mem_wr;
            be_r    <= issue_s ? lane_mask(i_struct.mem_size, in_off_s) : 8'h00;
            if (issue_s) begin
                addr_r  <= {i_struct.mem_addr[XLEN-1:3], 3'b000};
                wdata_r <= i_struct.mem_data << {in_off_s, 3'b000};
            end
        end else begin
            case (state_r)
                S_IDLE: state_r <= S_IDLE;
                S_REQ: begin
                    if (dmem_gnt) begin
                        state_r    <= S_WAIT;
                        req_r      <= 1'b0;
                        we_r       <= 1'b0;
                        be_r       <= 8'h00;
                        wait_cnt_r <= {CNT_W{1'b0}};
                    end
                end
                S_WAIT: begin
                    // A store's response is only an ack; a timed-out load keeps its old rf_wr_data.
                    if (dmem_rvalid) begin
                        state_r <= S_DONE;
                        if (!hold_r.mem_wr) begin
                            hold_r.rf_wr_data <= load_data_s;
                        end
                    end else if (timeout_s) begin
                        state_r        <= S_DONE;
                        hold_r.exc_bus <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        state_r <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign o_valid    = (state_r == S_DONE);
    assign o_struct   = hold_r;
    assign dmem_req   = req_r;
    assign dmem_we    = we_r;
    assign dmem_addr  = addr_r;
    assign dmem_be    = be_r;
    assign dmem_wdata = wdata_r;

endmodule
